// File: rtl/udp_tx_feeder.sv
// udp_tx_feeder: packs user bytes big-endian into a word buffer and feeds them to a UDP transmitter.
// Define UDP_TX_MIN_PAD_EN to report at least 18 payload bytes (minimum Ethernet frame).
module udp_tx_feeder #(
  parameter int MAX_BYTES = 1472,
  parameter int ADDR_W = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [31:0] tx_data,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic        busy
);
  typedef enum logic [1:0] {FILL, START, SEND} state_t;
  state_t st, st_n;
  logic [31:0] mem [2**ADDR_W];
  logic [31:0] acc, w;
  logic [15:0] cnt, cnt1, nw, rp, len;
  logic accept, close;
  assign in_ready = st == FILL && !rst;
  assign busy = st != FILL;
  assign accept = in_valid && in_ready;
  assign close = accept && (in_last || cnt == 16'(MAX_BYTES - 1));
  assign cnt1 = cnt + 16'd1;
  // Starting a new word clears the stale low bytes, so partial words are zero-filled.
  assign w = (cnt[1:0] == 2'd0 ? 32'h0 : acc) | ({in_data, 24'h0} >> {cnt[1:0], 3'b000});
`ifdef UDP_TX_MIN_PAD_EN
  assign len = cnt1 < 16'd18 ? 16'd18 : cnt1;
`else
  assign len = cnt1;
`endif
  always_comb begin
    st_n = st;
    if (st == FILL) st_n = close ? START : FILL;
    else if (st == START) st_n = SEND;
    else st_n = tx_done ? FILL : SEND;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= FILL;
    else st <= st_n;
  always_ff @(posedge clk)
    if (accept && (cnt[1:0] == 2'd3 || close)) mem[cnt[ADDR_W+1:2]] <= w;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      nw <= '0;
      rp <= '0;
      tx_byte_num <= '0;
      tx_data <= '0;
      tx_start_en <= 1'b0;
    end else begin
      tx_start_en <= st == START;
      if (accept) begin
        cnt <= cnt1;
        acc <= w;
      end
      if (close) begin
        tx_byte_num <= len;
        nw <= (cnt1 + 16'd3) >> 2;
      end
      if (st == START) begin
        tx_data <= mem[0];
        rp <= 16'd1;
      end
      // Read pointer parks at the word count so further requests return zero.
      if (st == SEND && tx_req) begin
        tx_data <= rp < nw ? mem[rp[ADDR_W-1:0]] : 32'h0;
        if (rp < nw) rp <= rp + 16'd1;
      end
      if (st == SEND && tx_done) begin
        cnt <= '0;
        rp <= '0;
      end
    end
  end
endmodule

// File: tb/tb_udp_tx_feeder.sv
// tb_udp_tx_feeder: directed checks of byte packing, start pulse, word requests, forced close and reset.
module tb_udp_tx_feeder;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, tx_req = 0, tx_done = 0;
  logic [7:0] in_data = 0;
  logic in_ready, tx_start_en, busy;
  logic [15:0] tx_byte_num;
  logic [31:0] tx_data;
  int checks = 0, errors = 0;

  udp_tx_feeder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num),
    .tx_data(tx_data), .tx_req(tx_req), .tx_done(tx_done), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef UDP_TX_MIN_PAD_EN
  function automatic logic [15:0] exp_len(input int n);
    return n < 18 ? 16'd18 : 16'(n);
  endfunction
`else
  function automatic logic [15:0] exp_len(input int n);
    return 16'(n);
  endfunction
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    in_valid = 1; in_data = d; in_last = l;
    tick;
    in_valid = 0; in_last = 0;
  endtask

  task automatic req;
    tx_req = 1;
    tick;
    tx_req = 0;
  endtask

  task automatic done;
    tx_done = 1;
    tick;
    tx_done = 0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!tx_start_en && n < 20) begin
      tick;
      n++;
    end
    chk(tag, {31'h0, tx_start_en}, 32'h1);
  endtask

  initial begin
    int acc_n, starts;
    tick;
    chk("rst_in_ready", {31'h0, in_ready}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_start", {31'h0, tx_start_en}, 0);
    chk("rst_byte_num", {16'h0, tx_byte_num}, 0);
    chk("rst_data", tx_data, 0);
    rst = 0;
    #1 chk("post_rst_ready", {31'h0, in_ready}, 1);
    tick;
    // 8 bytes 01..08
    for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
    chk("p1_ready_drop", {31'h0, in_ready}, 0);
    chk("p1_busy", {31'h0, busy}, 1);
    wait_start("p1_start");
    chk("p1_len", {16'h0, tx_byte_num}, {16'h0, exp_len(8)});
    chk("p1_w0", tx_data, 32'h01020304);
    tick;
    chk("p1_pulse_one", {31'h0, tx_start_en}, 0);
    req;
    chk("p1_w1", tx_data, 32'h05060708);
    req;
    chk("p1_w2", tx_data, 32'h0);
    done;
    chk("p1_idle", {31'h0, busy}, 0);
    chk("p1_ready", {31'h0, in_ready}, 1);
    // 5 bytes AA..EE
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0); send_byte(8'hEE, 1);
    wait_start("p2_start");
    chk("p2_len", {16'h0, tx_byte_num}, {16'h0, exp_len(5)});
    chk("p2_w0", tx_data, 32'hAABBCCDD);
    req;
    chk("p2_w1", tx_data, 32'hEE000000);
    req;
    chk("p2_w2", tx_data, 32'h0);
    done;
    // 1500 bytes without last: forced close at 1472
    acc_n = 0; starts = 0;
    for (int i = 0; i < 1500; i++) begin
      in_valid = 1; in_data = 8'(i);
      if (in_ready) acc_n++;
      if (tx_start_en) starts++;
      tick;
    end
    in_valid = 0;
    chk("p3_accepted", 32'(acc_n), 1472);
    chk("p3_starts", 32'(starts), 1);
    chk("p3_len", {16'h0, tx_byte_num}, 1472);
    chk("p3_ready_low", {31'h0, in_ready}, 0);
    chk("p3_w0", tx_data, 32'h00010203);
    for (int i = 0; i < 367; i++) req;
    chk("p3_wlast", tx_data, 32'hBCBDBEBF);
    req;
    chk("p3_past_end", tx_data, 32'h0);
    // bytes offered during SEND are not taken
    in_valid = 1; in_data = 8'h55;
    tick; tick;
    chk("p3_ready_send", {31'h0, in_ready}, 0);
    done;
    in_valid = 0;
    chk("p4_ready", {31'h0, in_ready}, 1);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 1);
    wait_start("p4_start");
    chk("p4_w0", tx_data, 32'h11223300);
    chk("p4_len", {16'h0, tx_byte_num}, {16'h0, exp_len(3)});
    done;
    // tx_done in FILL keeps the partial packet
    send_byte(8'hA1, 0); send_byte(8'hA2, 0);
    done;
    chk("p5_fill_busy", {31'h0, busy}, 0);
    chk("p5_fill_ready", {31'h0, in_ready}, 1);
    send_byte(8'hA3, 1);
    wait_start("p5_start");
    chk("p5_w0", tx_data, 32'hA1A2A300);
    chk("p5_len", {16'h0, tx_byte_num}, {16'h0, exp_len(3)});
    done;
    // reset mid-SEND
    for (int i = 0; i < 16; i++) send_byte(8'(i), i == 15);
    wait_start("p6_start");
    req; req; req;
    chk("p6_w3", tx_data, 32'h0C0D0E0F);
    rst = 1;
    #1;
    chk("p6_rst_ready", {31'h0, in_ready}, 0);
    chk("p6_rst_busy", {31'h0, busy}, 0);
    chk("p6_rst_data", tx_data, 0);
    chk("p6_rst_len", {16'h0, tx_byte_num}, 0);
    chk("p6_rst_start", {31'h0, tx_start_en}, 0);
    tick;
    rst = 0;
    tick;
    for (int i = 0; i < 4; i++) send_byte(8'(8'h21 + i), i == 3);
    wait_start("p7_start");
    chk("p7_w0", tx_data, 32'h21222324);
    chk("p7_len", {16'h0, tx_byte_num}, {16'h0, exp_len(4)});
    req;
    chk("p7_w1", tx_data, 32'h0);
    done;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/udp_tx_feeder.md
UDP_TX_FEEDER -- requirements
Module: udp_tx_feeder

Interface
REQ-001 The block SHALL have parameter MAX_BYTES, default 1472, the maximum UDP payload bytes per packet.
REQ-002 The block SHALL have parameter ADDR_W, default 9, the word-buffer address width (512 x 32-bit words).
REQ-003 clk  input  1  the only clock, driven from gmii_tx_clk; all logic SHALL be in this domain.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  user byte valid.
REQ-006 in_data  input  8  user payload byte.
REQ-007 in_last  input  1  marks the final byte of a packet; qualified by in_valid.
REQ-008 in_ready  output  1  the block accepts a byte when in_valid and in_ready are both high.
REQ-009 tx_start_en  output  1  one-cycle start pulse to the UDP transmitter.
REQ-010 tx_byte_num  output  16  payload byte count of the packet being sent.
REQ-011 tx_data  output  32  payload word to the transmitter.
REQ-012 tx_req  input  1  word request from the transmitter.
REQ-013 tx_done  input  1  one-cycle packet-sent pulse from the transmitter.
REQ-014 busy  output  1  high in every state except FILL.

Function
REQ-015 The block SHALL run the state machine FILL -> START -> SEND -> FILL, with no other states.
REQ-016 FILL: in_ready SHALL be high; each accepted byte SHALL be packed big-endian (1st byte [31:24] ... 4th byte [7:0]) and written to the buffer when a word completes or on the last byte.
REQ-017 A partial last word SHALL be zero-filled in its unused low bytes.
REQ-018 The packet SHALL close on an accepted byte with in_last=1, or on the MAX_BYTES-th accepted byte regardless of in_last (forced close).
REQ-019 On close, tx_byte_num SHALL latch the accepted byte count; in_ready SHALL drop on the next edge; the state SHALL become START.
REQ-020 START: the block SHALL load word 0 into tx_data, pulse tx_start_en high for exactly one cycle, then enter SEND.
REQ-021 SEND: each cycle tx_req is sampled high SHALL advance tx_data to the next buffered word on the following edge.
REQ-022 Requests beyond the last valid word SHALL return 32'h0.
REQ-023 SEND: tx_done SHALL clear the byte count and read/write pointers, and return the state to FILL in the next cycle.
REQ-024 tx_done outside SEND, and tx_req outside SEND, SHALL be ignored.
REQ-025 tx_byte_num and tx_data SHALL remain stable from START until tx_done.
REQ-026 in_valid while in_ready=0 SHALL not be accepted and SHALL have no effect.
REQ-027 A zero-byte packet SHALL be impossible: a packet always holds at least one byte.

Reset
REQ-028 When rst is asserted, the block SHALL enter FILL with all pointers and counters at 0.
REQ-029 Output reset values SHALL be: in_ready=0 while rst is high, then 1; tx_start_en=0; tx_byte_num=0; tx_data=0; busy=0.
REQ-030 Reset mid-packet, in FILL or SEND, SHALL discard the packet; buffer contents need not be cleared.

Configuration
REQ-031 Macro UDP_TX_MIN_PAD_EN defined: a packet closed with fewer than 18 bytes SHALL report tx_byte_num=18, and bytes beyond the accepted count SHALL read as 0 (minimum 64-byte Ethernet frame).
REQ-032 Macro UDP_TX_MIN_PAD_EN undefined: tx_byte_num SHALL equal the accepted byte count exactly.

Verification
REQ-033 Input 8 bytes 01..08 with last on 08 -> one tx_start_en pulse; tx_byte_num=8; tx_data=32'h01020304, then 32'h05060708 after 1st tx_req, then 0.
REQ-034 Input 5 bytes AA..EE with last -> words 32'hAABBCCDD and 32'hEE000000; tx_byte_num=18 with UDP_TX_MIN_PAD_EN, 5 without.
REQ-035 Input 1500 bytes with no in_last -> close after byte 1472; tx_byte_num=1472; in_ready low until tx_done.
REQ-036 Drive in_valid during SEND -> no byte accepted; after tx_done the next packet's first word starts with the first byte offered after in_ready rises.
REQ-037 Assert rst mid-SEND after 3 tx_req -> outputs return to reset values; a new 4-byte packet is then sent correctly with tx_byte_num=4.
REQ-038 Pulse tx_done in FILL -> no state change; partially filled packet preserved.
